// File: rtl/riscv_rf_ctx_engine_pkg.sv
// Shared definitions for the RF context save/restore engine.
//   riscv_dift_config : DIFT enable and the tag type carried alongside every register.
//   riscv_ctx_pkg     : FSM state encoding, first register index and the last-index helper.
// No ports; imported by the interface, the address sequencer and the engine top.

package riscv_dift_config;

    localparam bit DIFT_ACTIVE = 1'b1;
    localparam int DIFT_TAG_W  = 2;

    typedef logic [DIFT_TAG_W-1:0] dift_tag_t;

endpackage

package riscv_ctx_pkg;

    typedef riscv_dift_config::dift_tag_t dift_tag_t;
    localparam bit DIFT_ACTIVE = riscv_dift_config::DIFT_ACTIVE;

    typedef enum logic [1:0] {
        CTX_IDLE,
        CTX_SAVE,
        CTX_RESTORE
    } ctx_state_e;

    // x0 is hardwired to zero, so it is never saved or restored.
    localparam int CTX_FIRST_IDX = 1;

    // With a separate FP file the FP registers sit at 32..63 directly after the
    // X registers, so f0 (address 32) is part of the range.
    function automatic int ctx_last_idx(input bit fpu, input bit zfinx);
        return (fpu && !zfinx) ? 63 : 31;
    endfunction

endpackage

// File: rtl/riscv_rf_ctx_engine_if.sv
// Streaming interface of the RF context engine.
//   Save stream    : out_valid_o/out_ready_i with beat {out_addr_o, out_data_o, out_tag_o}
//   Restore stream : in_valid_i/in_ready_o with beat {in_data_i, in_tag_i}
// Modports:
//   master : the engine side (drives save beats and restore ready)
//   slave  : the peer side (memory/stack logic that consumes saves and sources restores)

interface riscv_rf_ctx_engine_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    import riscv_ctx_pkg::*;

    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [ADDR_WIDTH-1:0] out_addr_o;
    logic [DATA_WIDTH-1:0] out_data_o;
    dift_tag_t             out_tag_o;

    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] in_data_i;
    dift_tag_t             in_tag_i;

    modport master (
        output out_valid_o, out_addr_o, out_data_o, out_tag_o, in_ready_o,
        input  out_ready_i, in_valid_i, in_data_i, in_tag_i
    );

    modport slave (
        input  out_valid_o, out_addr_o, out_data_o, out_tag_o, in_ready_o,
        output out_ready_i, in_valid_i, in_data_i, in_tag_i
    );

endinterface

// File: rtl/riscv_rf_ctx_addr_seq.sv
// Register index sequencer shared by SAVE and RESTORE.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : restart the sequence at the first register index
//   inc        : advance by one (saturates at LAST_IDX, never wraps)
//   idx        : current register index
//   last       : idx equals LAST_IDX

module riscv_rf_ctx_addr_seq
    import riscv_ctx_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int LAST_IDX   = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] idx,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] idx_reg;

    assign last = (idx_reg == ADDR_WIDTH'(LAST_IDX));
    assign idx  = idx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg <= '0;
        end else if (load) begin
            idx_reg <= ADDR_WIDTH'(CTX_FIRST_IDX);
        end else if (inc && !last) begin
            idx_reg <= idx_reg + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/riscv_rf_ctx_engine.sv
// Register-file context save/restore engine.
// SAVE reads registers 1..LAST through one RF read port and streams {addr,data,tag}
// beats out; RESTORE accepts an in-order beat stream and writes registers 1..LAST
// through one RF write port. busy_o tells the integration to mux these RF ports
// onto read/write port A.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   save_req_i, restore_req_i   : start requests, sampled in IDLE only (save wins)
//   abort_i                     : abandon the current operation, no done_o
//   busy_o, done_o              : engine owns the RF ports / 1-cycle completion pulse
//   rf_raddr_o, rf_rdata_i,
//   rf_rtag_i                   : RF read port (data combinational from address)
//   rf_we_o, rf_waddr_o,
//   rf_wdata_o, rf_wtag_o       : RF write port
//   strm                        : save/restore beat streams (master side)

module riscv_rf_ctx_engine
    import riscv_ctx_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter bit FPU        = 1'b0,
    parameter bit Zfinx      = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  save_req_i,
    input  logic                  restore_req_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] rf_raddr_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_i,
    input  dift_tag_t             rf_rtag_i,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output dift_tag_t             rf_wtag_o,
    riscv_rf_ctx_engine_if.master strm
);

    localparam int LAST_IDX = ctx_last_idx(FPU, Zfinx);

    ctx_state_e            state_reg;
    ctx_state_e            state_next;
    logic                  done_reg;
    logic                  done_next;
    logic                  rd_pending_reg;
    logic                  out_valid_reg;
    logic [ADDR_WIDTH-1:0] out_addr_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;
    dift_tag_t             out_tag_reg;

    logic                  seq_load;
    logic                  seq_inc;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  idx_last;

    logic in_save;
    logic in_restore;
    logic save_load;
    logic save_fire;
    logic save_end;
    logic in_fire;

    riscv_rf_ctx_addr_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LAST_IDX   (LAST_IDX)
    ) u_addr_seq (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (seq_load),
        .inc   (seq_inc),
        .idx   (idx),
        .last  (idx_last)
    );

    assign in_save    = (state_reg == CTX_SAVE);
    assign in_restore = (state_reg == CTX_RESTORE);

    // The output register refills whenever a read is outstanding and the slot is
    // empty or being emptied this cycle, giving one beat per cycle under ready=1.
    assign save_load = in_save && rd_pending_reg && (!out_valid_reg || strm.out_ready_i);
    assign save_fire = out_valid_reg && strm.out_ready_i;
    // No read left to issue, so the beat leaving now is the LAST register.
    assign save_end  = in_save && save_fire && !rd_pending_reg;
    assign in_fire   = in_restore && strm.in_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= CTX_IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        seq_load   = 1'b0;
        seq_inc    = 1'b0;
        unique case (state_reg)
            CTX_IDLE: begin
                if (save_req_i) begin
                    state_next = CTX_SAVE;
                    seq_load   = 1'b1;
                end else if (restore_req_i) begin
                    state_next = CTX_RESTORE;
                    seq_load   = 1'b1;
                end
            end
            CTX_SAVE: begin
                if (save_load && !idx_last) begin
                    seq_inc = 1'b1;
                end
                if (save_end) begin
                    state_next = CTX_IDLE;
                    done_next  = 1'b1;
                end
            end
            CTX_RESTORE: begin
                if (in_fire) begin
                    if (idx_last) begin
                        state_next = CTX_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        seq_inc = 1'b1;
                    end
                end
            end
            default: begin
                state_next = CTX_IDLE;
            end
        endcase
        // Abort overrides everything; a restore beat in this cycle is still
        // written because rf_we_o is combinational from the handshake.
        if (abort_i) begin
            state_next = CTX_IDLE;
            done_next  = 1'b0;
            seq_load   = 1'b0;
            seq_inc    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending_reg <= 1'b0;
        end else if (abort_i) begin
            rd_pending_reg <= 1'b0;
        end else if ((state_reg == CTX_IDLE) && (state_next == CTX_SAVE)) begin
            rd_pending_reg <= 1'b1;
        end else if (save_load && idx_last) begin
            rd_pending_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_addr_reg  <= '0;
            out_data_reg  <= '0;
            out_tag_reg   <= '0;
        end else if (abort_i) begin
            out_valid_reg <= 1'b0;
        end else if (save_load) begin
            out_valid_reg <= 1'b1;
            out_addr_reg  <= idx;
            out_data_reg  <= rf_rdata_i;
            out_tag_reg   <= DIFT_ACTIVE ? rf_rtag_i : '0;
        end else if (save_fire) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign busy_o           = (state_reg != CTX_IDLE);
    assign done_o           = done_reg;
    assign rf_raddr_o       = in_save ? idx : '0;

    assign strm.out_valid_o = out_valid_reg;
    assign strm.out_addr_o  = out_addr_reg;
    assign strm.out_data_o  = out_data_reg;
    assign strm.out_tag_o   = out_tag_reg;
    assign strm.in_ready_o  = in_restore;

    assign rf_we_o          = in_fire;
    assign rf_waddr_o       = in_restore ? idx : '0;
    assign rf_wdata_o       = in_restore ? strm.in_data_i : '0;
    assign rf_wtag_o        = (in_restore && DIFT_ACTIVE) ? strm.in_tag_i : '0;

endmodule

// File: tb/tb_riscv_rf_ctx_engine.sv
module tb_riscv_rf_ctx_engine;
    import riscv_ctx_pkg::*;

    localparam int AW  = 5;
    localparam int AWF = 6;
    localparam int DW  = 32;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
        logic [1:0]  tag;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, save_req, restore_req, abort;
    logic busy, done, rf_we;
    logic [AW-1:0] rf_raddr, rf_waddr;
    logic [DW-1:0] rf_rdata, rf_wdata;
    dift_tag_t rf_rtag, rf_wtag;

    riscv_rf_ctx_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) strm ();

    riscv_rf_ctx_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FPU(1'b0), .Zfinx(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .save_req_i(save_req), .restore_req_i(restore_req),
        .abort_i(abort), .busy_o(busy), .done_o(done),
        .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata), .rf_rtag_i(rf_rtag),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .rf_wtag_o(rf_wtag),
        .strm(strm)
    );

    // Second instance: separate FP file, 64 registers.
    logic f_save_req, f_restore_req, f_abort, f_busy, f_done, f_we;
    logic [AWF-1:0] f_raddr, f_waddr;
    logic [DW-1:0] f_rdata, f_wdata;
    dift_tag_t f_rtag, f_wtag;

    riscv_rf_ctx_engine_if #(.ADDR_WIDTH(AWF), .DATA_WIDTH(DW)) strm_f ();

    riscv_rf_ctx_engine #(.ADDR_WIDTH(AWF), .DATA_WIDTH(DW), .FPU(1'b1), .Zfinx(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n), .save_req_i(f_save_req), .restore_req_i(f_restore_req),
        .abort_i(f_abort), .busy_o(f_busy), .done_o(f_done),
        .rf_raddr_o(f_raddr), .rf_rdata_i(f_rdata), .rf_rtag_i(f_rtag),
        .rf_we_o(f_we), .rf_waddr_o(f_waddr), .rf_wdata_o(f_wdata), .rf_wtag_o(f_wtag),
        .strm(strm_f)
    );

    // Register file models (x0 preloaded 0 and never legally written).
    logic rf_init;
    logic [DW-1:0] rf_mem [0:31];
    dift_tag_t     rf_tmem[0:31];
    logic [DW-1:0] f_mem  [0:63];
    dift_tag_t     f_tmem [0:63];

    assign rf_rdata = rf_mem[rf_raddr];
    assign rf_rtag  = rf_tmem[rf_raddr];
    assign f_rdata  = f_mem[f_raddr];
    assign f_rtag   = f_tmem[f_raddr];

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) begin
                rf_mem[i]  <= (i == 0) ? '0 : DW'(32'h100 + i);
                rf_tmem[i] <= (i == 0) ? '0 : dift_tag_t'(i);
            end
        end else if (rf_we) begin
            rf_mem[rf_waddr]  <= rf_wdata;
            rf_tmem[rf_waddr] <= rf_wtag;
        end
    end

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 64; i++) begin
                f_mem[i]  <= (i == 0) ? '0 : DW'(32'h100 + i);
                f_tmem[i] <= (i == 0) ? '0 : dift_tag_t'(i);
            end
        end else if (f_we) begin
            f_mem[f_waddr]  <= f_wdata;
            f_tmem[f_waddr] <= f_wtag;
        end
    end

    // Reference model: what each architectural register should hold.
    logic [31:0] ref_data[0:31];
    logic [1:0]  ref_tag [0:31];

    beat_t exp_save[$];
    beat_t exp_wr[$];
    beat_t exp_fsave[$];

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0, beat_cnt = 0, f_done_cnt = 0, f_beat_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Main monitor: pops the scoreboard whenever a save beat or an RF write occurs.
    logic        last_hs_prev = 1'b0;
    logic        prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin : mon
        beat_t b;
        if (!rst_n) begin
            last_hs_prev = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            if (done || last_hs_prev) chk("done_timing", done, last_hs_prev);
            if (done) begin
                done_cnt++;
                chk("done_busy_overlap", busy, 1'b0);
            end
            if (prev_stall) begin
                chk("stall_valid", strm.out_valid_o, 1'b1);
                chk("stall_hold", {strm.out_addr_o, strm.out_data_o}, {prev_addr, prev_data});
            end
            last_hs_prev = 1'b0;
            if (strm.out_valid_o && strm.out_ready_i) begin
                beat_cnt++;
                if (exp_save.size() == 0) begin
                    chk("save_unexpected", 1, 0);
                end else begin
                    b = exp_save.pop_front();
                    chk("save_beat", {strm.out_addr_o, strm.out_data_o, strm.out_tag_o},
                        {b.addr[AW-1:0], b.data, b.tag});
                end
                if (strm.out_addr_o == AW'(31)) last_hs_prev = !abort;
            end
            if (rf_we) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    b = exp_wr.pop_front();
                    chk("rf_write", {rf_waddr, rf_wdata, rf_wtag}, {b.addr[AW-1:0], b.data, b.tag});
                end
                if (rf_waddr == AW'(31)) last_hs_prev = !abort;
            end
            prev_stall = strm.out_valid_o && !strm.out_ready_i && !abort;
            prev_addr  = strm.out_addr_o;
            prev_data  = strm.out_data_o;
        end
    end

    always @(negedge clk) begin : mon_f
        beat_t b;
        if (rst_n) begin
            if (f_done) f_done_cnt++;
            if (strm_f.out_valid_o && strm_f.out_ready_i) begin
                f_beat_cnt++;
                if (exp_fsave.size() == 0) begin
                    chk("fsave_unexpected", 1, 0);
                end else begin
                    b = exp_fsave.pop_front();
                    chk("fsave_beat", {strm_f.out_addr_o, strm_f.out_data_o, strm_f.out_tag_o},
                        {b.addr, b.data, b.tag});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_val(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 2) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_save(input int mode, input bit chk_lat, input bit both_req,
                            input bit mid_restore, input int abort_at);
        int d0 = done_cnt;
        int b0 = beat_cnt;
        bit aborted = 1'b0;
        beat_t b;
        for (int i = 1; i <= 31; i++) begin
            b.addr = 6'(i); b.data = ref_data[i]; b.tag = ref_tag[i];
            exp_save.push_back(b);
        end
        save_req = 1'b1;
        restore_req = both_req;
        strm.out_ready_i = ready_val(mode, 0);
        tick();
        save_req = 1'b0;
        restore_req = 1'b0;
        chk("save_busy", busy, 1'b1);
        chk("save_not_restore", strm.in_ready_o, 1'b0);
        if (chk_lat) begin
            chk("lat_c1_valid", strm.out_valid_o, 1'b0);
            chk("lat_c1_raddr", rf_raddr, 1);
            tick();
            chk("lat_c2_valid", strm.out_valid_o, 1'b1);
            chk("lat_c2_addr", strm.out_addr_o, 1);
        end
        for (int c = 0; c < 400 && done_cnt == d0 && !aborted; c++) begin
            strm.out_ready_i = (abort_at != 0) ? 1'b1 : ready_val(mode, c + 1);
            restore_req = mid_restore && (c == 5);
            if (abort_at != 0 && (beat_cnt - b0) == abort_at - 1) begin
                abort = 1'b1;
                aborted = 1'b1;
            end
            tick();
            restore_req = 1'b0;
            if (aborted) begin
                abort = 1'b0;
                chk("abort_idle", busy, 1'b0);
                chk("abort_valid", strm.out_valid_o, 1'b0);
            end
        end
        if (abort_at != 0) begin
            chk("abort_taken", aborted, 1'b1);
            chk("abort_left", exp_save.size(), 31 - abort_at);
            exp_save.delete();
            repeat (3) tick();
            chk("abort_no_done", done_cnt - d0, 0);
            chk("abort_beats", beat_cnt - b0, abort_at);
        end else begin
            chk("save_done_once", done_cnt - d0, 1);
            chk("save_beats", beat_cnt - b0, 31);
            chk("save_queue_empty", exp_save.size(), 0);
            tick();
            chk("idle_after_save", busy, 1'b0);
        end
        strm.out_ready_i = 1'b0;
    endtask

    task automatic run_restore(input bit pat_a, input int abort_at, input int reset_at);
        int d0 = done_cnt;
        bit stop = 1'b0;
        logic [31:0] data;
        logic [1:0] tag;
        beat_t b;
        restore_req = 1'b1;
        tick();
        restore_req = 1'b0;
        chk("restore_busy", busy, 1'b1);
        chk("restore_in_ready", strm.in_ready_o, 1'b1);
        for (int k = 1; k <= 31 && !stop; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            data = pat_a ? 32'hA000_0000 + 32'(k) : $urandom;
            tag  = 2'($urandom);
            strm.in_valid_i = 1'b1;
            strm.in_data_i = data;
            strm.in_tag_i = tag;
            if (k == reset_at) begin
                #3 rst_n = 1'b0;
                #1;
                chk("rstmid_busy", busy, 1'b0);
                chk("rstmid_we", rf_we, 1'b0);
                chk("rstmid_in_ready", strm.in_ready_o, 1'b0);
                chk("rstmid_wbus", {rf_waddr, rf_wdata, rf_wtag}, 0);
                chk("rstmid_done", done, 1'b0);
                strm.in_valid_i = 1'b0;
                tick();
                rst_n = 1'b1;
                stop = 1'b1;
            end else begin
                ref_data[k] = data;
                ref_tag[k] = tag;
                b.addr = 6'(k); b.data = data; b.tag = tag;
                exp_wr.push_back(b);
                abort = (k == abort_at);
                tick();
                strm.in_valid_i = 1'b0;
                if (abort) begin
                    abort = 1'b0;
                    chk("abort_restore_idle", busy, 1'b0);
                    stop = 1'b1;
                end
            end
        end
        if (abort_at != 0 || reset_at != 0) begin
            repeat (3) tick();
            chk("restore_no_done", done_cnt - d0, 0);
        end else begin
            for (int c = 0; c < 10 && done_cnt == d0; c++) tick();
            chk("restore_done_once", done_cnt - d0, 1);
        end
        chk("wr_queue_empty", exp_wr.size(), 0);
        tick();
        for (int i = 0; i < 32; i++)
            chk($sformatf("rf_x%0d", i), {rf_tmem[i], rf_mem[i]}, {ref_tag[i], ref_data[i]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        rst_n = 1'b0;
        save_req = 1'b0; restore_req = 1'b0; abort = 1'b0; rf_init = 1'b0;
        f_save_req = 1'b0; f_restore_req = 1'b0; f_abort = 1'b0;
        strm.out_ready_i = 1'b0; strm.in_valid_i = 1'b0;
        strm.in_data_i = '0; strm.in_tag_i = '0;
        strm_f.out_ready_i = 1'b1; strm_f.in_valid_i = 1'b0;
        strm_f.in_data_i = '0; strm_f.in_tag_i = '0;
        repeat (3) tick();
        chk("reset_busy_done", {busy, done}, 0);
        chk("reset_out", {strm.out_valid_o, strm.out_addr_o, strm.out_data_o, strm.out_tag_o}, 0);
        chk("reset_wr", {rf_we, rf_waddr, rf_wdata, rf_wtag, strm.in_ready_o}, 0);
        chk("reset_raddr", rf_raddr, 0);
        rst_n = 1'b1;
        rf_init = 1'b1;
        tick();
        rf_init = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ref_data[i] = (i == 0) ? 32'h0 : 32'h100 + 32'(i);
            ref_tag[i]  = 2'(i);
        end
        tick();

        run_save(0, 1'b1, 1'b0, 1'b0, 0);       // ready=1, latency check
        run_save(1, 1'b0, 1'b0, 1'b0, 0);       // ready toggling
        run_restore(1'b1, 0, 0);                // 0xA0000000+i with gaps
        run_save(2, 1'b0, 1'b0, 1'b0, 0);       // read back restored values
        run_restore(1'b0, 0, 0);                // random data
        run_save(2, 1'b0, 1'b1, 1'b1, 0);       // both reqs, restore_req mid-save
        run_save(0, 1'b0, 1'b0, 1'b0, 10);      // abort at beat 10
        run_restore(1'b0, 7, 0);                // abort on beat 7 (still written)
        run_restore(1'b0, 0, 6);                // reset mid-restore
        run_save(2, 1'b0, 1'b0, 1'b0, 0);       // engine healthy after reset

        // FP-file configuration: registers 1..63, f0 at address 32 included.
        for (int i = 1; i <= 63; i++) begin
            b.addr = 6'(i); b.data = 32'h100 + 32'(i); b.tag = 2'(i);
            exp_fsave.push_back(b);
        end
        f_save_req = 1'b1;
        tick();
        f_save_req = 1'b0;
        for (int c = 0; c < 200 && f_done_cnt == 0; c++) tick();
        chk("fsave_done_once", f_done_cnt, 1);
        chk("fsave_beats", f_beat_cnt, 63);
        chk("fsave_queue_empty", exp_fsave.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
